cam_dvp_transmitter: RTL
========================

CAM_DVP_TRANSMITTER -- requirements
Module: cam_dvp_transmitter

Interface
REQ-001 Parameter H_ACTIVE, 640, active pixels per line; each pixel is 2 bytes.
REQ-002 Parameter H_BLANK, 144, PCLK cycles of horizontal blanking per line.
REQ-003 Parameter V_ACTIVE, 480, active lines per frame.
REQ-004 Parameter V_SYNC, 3, line periods with CamVsync high.
REQ-005 Parameter V_BP, 17, blank line periods after VSYNC.
REQ-006 Parameter V_FP, 10, blank line periods after the last active line.
REQ-007 reset  input  1  asynchronous, active-high.
REQ-008 PCLK  input  1  pixel clock; all logic on the rising edge.
REQ-009 enable  input  1  frame generation request, level.
REQ-010 pix_data  input  16  pixel word; [15:8] sent first, [7:0] second.
REQ-011 pix_valid  input  1  pix_data valid.
REQ-012 pix_ready  output  1  word accepted on the edge where pix_valid and pix_ready are both high.
REQ-013 CamHsync  output  1  high during the active bytes of an active line.
REQ-014 CamVsync  output  1  high during the VSYNC line periods.
REQ-015 CamData_out  output  8  byte stream.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 frame_done  output  1  one-cycle pulse at the end of the VFP.
REQ-018 underflow  output  1  sticky; set on a pixel slot with no valid word.

Function
REQ-019 Line period SHALL be LINE_LEN = 2*H_ACTIVE + H_BLANK cycles; the horizontal counter runs 0..LINE_LEN-1 and wraps.
REQ-020 The FSM SHALL have states IDLE, VSYNC, VBP, ACTIVE, VFP; the vertical line counter increments on each horizontal wrap.
REQ-021 IDLE -> VSYNC on the first edge with enable=1; the horizontal and line counters SHALL start at 0.
REQ-022 VSYNC -> VBP after V_SYNC lines, VBP -> ACTIVE after V_BP lines, ACTIVE -> VFP after V_ACTIVE lines.
REQ-023 VFP SHALL last V_FP lines, then pulse frame_done for 1 cycle.
REQ-024 At the VFP end, the next state SHALL be VSYNC if enable=1, else IDLE; frame-to-frame spacing has no gap cycles.
REQ-025 Deasserting enable mid-frame SHALL NOT truncate the frame; the frame completes, then the block returns to IDLE.
REQ-026 All of CamHsync, CamVsync and CamData_out SHALL be registered outputs.
REQ-027 In ACTIVE, output cycles with hcnt 0..2*H_ACTIVE-1 SHALL have CamHsync=1; hcnt >= 2*H_ACTIVE SHALL have CamHsync=0 and CamData_out=0x00.
REQ-028 pix_ready SHALL be high exactly in the cycle before each even active byte cycle, i.e. H_ACTIVE times per active line, and low otherwise, including in IDLE.
REQ-029 A word accepted at edge N SHALL give CamData_out=pix_data[15:8] in cycle N+1 and pix_data[7:0] in cycle N+2, from a holding register.
REQ-030 If pix_valid=0 while pix_ready=1, both bytes of that slot SHALL be 0x00; timing SHALL NOT stall; underflow SHALL be set to 1.
REQ-031 underflow SHALL clear only on reset or on the IDLE->VSYNC transition.
REQ-032 CamVsync=1 for the entire VSYNC state (V_SYNC*LINE_LEN cycles), 0 elsewhere; CamHsync=0 outside ACTIVE.
REQ-033 Counter widths SHALL be sized by clog2 of LINE_LEN and of the maximum vertical state length; no overflow for default parameters.

Reset
REQ-034 On reset: state=IDLE, counters=0, CamHsync=0, CamVsync=0, CamData_out=0x00, pix_ready=0, busy=0, frame_done=0, underflow=0.
REQ-035 Reset asserted mid-frame SHALL abort immediately to the reset values; restart follows REQ-021.

Verification (H_ACTIVE=4, H_BLANK=3, V_ACTIVE=2, V_SYNC=1, V_BP=1, V_FP=1; LINE_LEN=11)
REQ-036 Case 1: enable=1 with an always-valid source of words 0x0102, 0x0304, ... -> CamVsync high 11 cycles; after 11 VBP cycles, CamHsync high 8 cycles with bytes 01,02,03,04,05,06,07,08, then low 3 cycles; frame_done pulses at frame cycle 55.
REQ-037 Case 2: pix_valid=0 for the 2nd slot of line 0 -> bytes 01,02,00,00,03,04,05,06; underflow=1 and stays 1 through the next frame until the next IDLE->VSYNC transition.
REQ-038 Case 3: enable held 1 -> the second frame's CamVsync rises in the cycle after the frame_done pulse; pix_ready count is 8 per frame.
REQ-039 Case 4: enable dropped in frame cycle 20 -> the frame completes through VFP, then busy=0 and all outputs stay 0.
REQ-040 Case 5: reset during the 3rd active byte -> all outputs at reset values on the next cycle; re-enable reproduces Case 1 exactly.

Source files
------------

// File: rtl/cam_dvp_transmitter.sv
// DVP camera-style byte transmitter: frames VSYNC/VBP/ACTIVE/VFP, two bytes per pixel word.
// Outputs registered (1-cycle latency from accept); no stall: a missing word sends zeros and sets sticky underflow.
module cam_dvp_transmitter #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 144,
  parameter int V_ACTIVE = 480,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 17,
  parameter int V_FP     = 10
) (
  input  logic        PCLK,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        CamHsync,
  output logic        CamVsync,
  output logic [7:0]  CamData_out,
  output logic        busy,
  output logic        frame_done,
  output logic        underflow
);

  localparam int LINE_LEN  = 2 * H_ACTIVE + H_BLANK;
  localparam int ACT_BYTES = 2 * H_ACTIVE;
  localparam int V_MAX_A   = (V_SYNC > V_BP) ? V_SYNC : V_BP;
  localparam int V_MAX_B   = (V_ACTIVE > V_FP) ? V_ACTIVE : V_FP;
  localparam int V_MAX     = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
  localparam int HW        = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int VW        = (V_MAX > 1) ? $clog2(V_MAX) : 1;

  localparam logic [HW-1:0] H_LAST  = HW'(LINE_LEN - 1);
  localparam logic [HW:0]   ACT_END = (HW + 1)'(ACT_BYTES);
  localparam logic [VW-1:0] VS_LAST = VW'(V_SYNC - 1);
  localparam logic [VW-1:0] VB_LAST = VW'(V_BP - 1);
  localparam logic [VW-1:0] VA_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VF_LAST = VW'(V_FP - 1);

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBP,
    ACTIVE,
    VFP
  } state_t;

  state_t          state, state_nxt;
  logic [HW-1:0]   hcnt, hcnt_nxt;
  logic [VW-1:0]   vcnt, vcnt_nxt;
  logic [VW-1:0]   v_last;
  logic            line_end;
  logic            hs_nxt;
  logic            fd_nxt;
  logic [7:0]      data_nxt;
  logic [7:0]      lo_hold;

  assign line_end = (hcnt == H_LAST);
  assign busy     = (state != IDLE);

  always_ff @(posedge PCLK or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      hcnt  <= '0;
      vcnt  <= '0;
    end else begin
      state <= state_nxt;
      hcnt  <= hcnt_nxt;
      vcnt  <= vcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hcnt_nxt  = hcnt;
    vcnt_nxt  = vcnt;
    v_last    = '0;
    case (state)
      VSYNC:   v_last = VS_LAST;
      VBP:     v_last = VB_LAST;
      ACTIVE:  v_last = VA_LAST;
      VFP:     v_last = VF_LAST;
      default: v_last = '0;
    endcase

    if (state == IDLE) begin
      hcnt_nxt = '0;
      vcnt_nxt = '0;
      if (enable) state_nxt = VSYNC;
    end else begin
      hcnt_nxt = line_end ? '0 : hcnt + 1'b1;
      if (line_end) begin
        if (vcnt == v_last) begin
          vcnt_nxt = '0;
          case (state)
            VSYNC:   state_nxt = VBP;
            VBP:     state_nxt = ACTIVE;
            ACTIVE:  state_nxt = VFP;
            VFP:     state_nxt = enable ? VSYNC : IDLE;
            default: state_nxt = IDLE;
          endcase
        end else begin
          vcnt_nxt = vcnt + 1'b1;
        end
      end
    end
  end

  // Output registers are loaded from the next-cycle position so they line up with state.
  assign hs_nxt    = (state_nxt == ACTIVE) && ({1'b0, hcnt_nxt} < ACT_END);
  assign pix_ready = hs_nxt && !hcnt_nxt[0];
  assign fd_nxt    = (state_nxt == VFP) && (hcnt_nxt == H_LAST) && (vcnt_nxt == VF_LAST);

  always_comb begin
    data_nxt = 8'h00;
    if (pix_ready) begin
      data_nxt = pix_valid ? pix_data[15:8] : 8'h00;
    end else if (hs_nxt) begin
      data_nxt = lo_hold;
    end
  end

  always_ff @(posedge PCLK or posedge reset) begin
    if (reset) begin
      CamHsync    <= 1'b0;
      CamVsync    <= 1'b0;
      CamData_out <= 8'h00;
      frame_done  <= 1'b0;
      lo_hold     <= 8'h00;
      underflow   <= 1'b0;
    end else begin
      CamHsync    <= hs_nxt;
      CamVsync    <= (state_nxt == VSYNC);
      CamData_out <= data_nxt;
      frame_done  <= fd_nxt;
      if (pix_ready) lo_hold <= pix_valid ? pix_data[7:0] : 8'h00;
      if (state == IDLE && enable) begin
        underflow <= 1'b0;
      end else if (pix_ready && !pix_valid) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule
